// File: rtl/alu_operand_issue.sv
// alu_operand_issue
//   Operand-fetch stage in front of the ALU. It holds the integer register
//   file and reads rs1/rs2 (or takes the immediate as operand B). It hands
//   {a, b, op, rd} to the ALU through a valid/ready handshake that has a
//   2-entry skid buffer (a main slot plus a skid slot).
//
// Optional feature (compile-time macro OPERAND_SCOREBOARD_EN):
//   Adds a pending-destination scoreboard that stalls requests which read a
//   register whose result has not been written back yet.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     issue request handshake
//   rs1_i, rs2_i                  source register addresses
//   imm_i, use_imm_i              immediate, and the select for operand B
//   op_i, rd_i                    opcode and destination, passed through unchanged
//   wb_en_i, wb_addr_i, wb_data_i writeback port from the result stage
//   alu_valid_o / alu_ready_i     operand handshake toward the ALU
//   a_o, b_o, op_o, rd_o          operands presented to the ALU
module alu_operand_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [$clog2(NREGS)-1:0] rs1_i,
    input  logic [$clog2(NREGS)-1:0] rs2_i,
    input  logic [XLEN-1:0]          imm_i,
    input  logic                     use_imm_i,
    input  logic [4:0]               op_i,
    input  logic [$clog2(NREGS)-1:0] rd_i,
    input  logic                     wb_en_i,
    input  logic [$clog2(NREGS)-1:0] wb_addr_i,
    input  logic [XLEN-1:0]          wb_data_i,
    output logic                     alu_valid_o,
    input  logic                     alu_ready_i,
    output logic [XLEN-1:0]          a_o,
    output logic [XLEN-1:0]          b_o,
    output logic [4:0]               op_o,
    output logic [$clog2(NREGS)-1:0] rd_o
);

    localparam int unsigned AW  = $clog2(NREGS);
    localparam int unsigned OPW = 5;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  op;
        logic [AW-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            ready_q;
    logic            accept;
    logic            consume;
    logic            load_main;
    logic            load_skid;
    logic            main_from_skid;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          new_entry;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] rf [NREGS];

    // Register-file read. x0 reads as zero. A same-cycle writeback is forwarded.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_i != '0) begin
            if (wb_en_i && (wb_addr_i == rs1_i)) rs1_data = wb_data_i;
            else                                 rs1_data = rf[rs1_i];
        end
        if (rs2_i != '0) begin
            if (wb_en_i && (wb_addr_i == rs2_i)) rs2_data = wb_data_i;
            else                                 rs2_data = rf[rs2_i];
        end
    end

    always_comb begin
        new_entry.a  = rs1_data;
        new_entry.b  = use_imm_i ? imm_i : rs2_data;
        new_entry.op = op_i;
        new_entry.rd = rd_i;
    end

`ifdef OPERAND_SCOREBOARD_EN
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pending_eff;
    logic             hazard;

    // Pending bits net of this cycle's writeback. A set wins over a clear on the same index.
    always_comb begin
        clr_mask    = wb_en_i ? (NREGS'(1) << wb_addr_i) : '0;
        set_mask    = (accept && (rd_i != '0)) ? (NREGS'(1) << rd_i) : '0;
        pending_eff = pending_q & ~clr_mask;
        pending_d   = pending_eff | set_mask;
        hazard      = req_valid_i &&
                      (((rs1_i != '0) && pending_eff[rs1_i]) ||
                       (!use_imm_i && (rs2_i != '0) && pending_eff[rs2_i]));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign req_ready_o = ready_q && !hazard;
`else
    assign req_ready_o = ready_q;
`endif

    assign accept  = req_valid_i && req_ready_o;
    assign consume = alu_valid_o && alu_ready_i;

    // Skid FSM next-state and slot-load decisions.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d   = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = S_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (consume) begin
                    state_d        = S_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State register. Valid and ready are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_EMPTY;
            alu_valid_o <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            alu_valid_o <= (state_d != S_EMPTY);
            ready_q     <= (state_d != S_FULL);
        end
    end

    // Main and skid slots. The main slot drives the ALU operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= new_entry;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= new_entry;
        end
    end

    assign a_o  = main_q.a;
    assign b_o  = main_q.b;
    assign op_o = main_q.op;
    assign rd_o = main_q.rd;

    // Register file storage. x0 is never written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else if (wb_en_i && (wb_addr_i != '0)) begin
            rf[wb_addr_i] <= wb_data_i;
        end
    end

endmodule
